pkt_frame_rx: RTL and testbench

Receive-side framer that sits directly upstream of the reward top module. It accepts a stream of 16-bit words over a valid/ready handshake and assembles six-word neighbour frames: five fields plus a checksum. Each frame is validated for checksum and destination. For every accepted frame it presents the five fields, pulses `en` for one cycle, and holds off further input until the reward stage returns `done_reward`.

---
 rtl/pkt_frame_rx_if.sv | 17 +
 rtl/pkt_frame_rx.sv | 174 +++++++++++++++++
 tb/tb_pkt_frame_rx.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_frame_rx_if.sv
// pkt_frame_rx_if: valid/ready word stream feeding the receive framer.
//   in_data  : stream word
//   in_sof   : first word of a frame, qualified by in_valid
//   in_valid : in_data/in_sof are valid
//   in_ready : receiver accepts a word this cycle
// master drives the stream, slave (the framer) returns in_ready.
interface pkt_frame_rx_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_sof;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, in_sof, in_valid, input in_ready);
  modport slave  (input in_data, in_sof, in_valid, output in_ready);
endinterface

// File: rtl/pkt_frame_rx.sv
// pkt_frame_rx: assembles six-word neighbour frames (five fields + checksum)
// from a word stream, validates checksum and destination, and hands accepted
// frames to the reward stage.
//   clock, rst        : single clock, async active-high reset
//   rx                : word stream (slave side)
//   f*                : fields of the last accepted frame
//   en                : one-cycle start pulse to the reward stage
//   done_reward       : reward stage finished the current frame
//   busy              : state is not IDLE
//   drop_count        : dropped frames, saturating at 255
//   pkt_count         : completed frames, wraps at 256
//   err_csum          : one-cycle pulse on checksum mismatch
//
// state     | meaning
// IDLE      | waiting for a start-of-frame word
// COLLECT   | capturing words 1..5, idle timer running
// CHECK     | compare checksum and destination
// ISSUE     | pulse en
// WAIT_DONE | hold off input until done_reward
module pkt_frame_rx #(
  parameter int WORD_WIDTH = 16,
  parameter int MY_ID      = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  rst,
  pkt_frame_rx_if.slave         rx,
  output logic [WORD_WIDTH-1:0] fsourceID,
  output logic [WORD_WIDTH-1:0] fbatteryStat,
  output logic [WORD_WIDTH-1:0] fValue,
  output logic [WORD_WIDTH-1:0] fclusterID,
  output logic [WORD_WIDTH-1:0] fdestinationID,
  output logic                  en,
  input  logic                  done_reward,
  output logic                  busy,
  output logic [7:0]            drop_count,
  output logic [7:0]            pkt_count,
  output logic                  err_csum
);

  localparam logic [WORD_WIDTH-1:0] MY_ID_W   = WORD_WIDTH'(MY_ID);
  localparam logic [7:0]            IDLE_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, ISSUE, WAIT_DONE} state_t;

  state_t                state, state_nx;
  logic [2:0]            idx, idx_nx, wr_idx;
  logic [7:0]            idle_cnt, idle_cnt_nx;
  logic                  ready_q;
  logic [WORD_WIDTH-1:0] cap [5];
  logic [WORD_WIDTH-1:0] cap_csum;
  logic [WORD_WIDTH-1:0] csum_calc;
  logic                  xfer, store, load, drop_inc, pkt_inc, csum_ok, dest_ok;

  // in_ready is registered from the next state so it stays low during reset
  // and has no path from in_valid.
  assign rx.in_ready = ready_q;
  assign xfer        = rx.in_valid & ready_q;
  assign busy        = (state != IDLE);
  assign csum_calc   = cap[0] + cap[1] + cap[2] + cap[3] + cap[4];
  assign csum_ok     = (csum_calc == cap_csum);
  assign dest_ok     = (cap[4] == MY_ID_W) || (cap[4] == {WORD_WIDTH{1'b1}});

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    idle_cnt_nx = idle_cnt;
    wr_idx      = 3'd0;
    store       = 1'b0;
    load        = 1'b0;
    drop_inc    = 1'b0;
    pkt_inc     = 1'b0;
    en          = 1'b0;
    err_csum    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && rx.in_sof) begin
          store       = 1'b1;
          idx_nx      = 3'd1;
          idle_cnt_nx = 8'd0;
          state_nx    = COLLECT;
        end
      end
      COLLECT: begin
        if (xfer) begin
          store       = 1'b1;
          idle_cnt_nx = 8'd0;
          if (rx.in_sof) begin
            // a new frame start abandons the partial one
            drop_inc = 1'b1;
            idx_nx   = 3'd1;
          end else begin
            wr_idx = idx;
            if (idx == 3'd5) begin
              idx_nx   = 3'd0;
              state_nx = CHECK;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end
        end else if (idle_cnt == IDLE_LAST) begin
          drop_inc    = 1'b1;
          idx_nx      = 3'd0;
          idle_cnt_nx = 8'd0;
          state_nx    = IDLE;
        end else begin
          idle_cnt_nx = idle_cnt + 8'd1;
        end
      end
      CHECK: begin
        state_nx = IDLE;
        if (!csum_ok) begin
          err_csum = 1'b1;
          drop_inc = 1'b1;
        end else if (!dest_ok) begin
          drop_inc = 1'b1;
        end else begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        en       = 1'b1;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_reward) begin
          pkt_inc  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 3'd0;
      idle_cnt       <= 8'd0;
      ready_q        <= 1'b0;
      for (int i = 0; i < 5; i++) cap[i] <= '0;
      cap_csum       <= '0;
      fsourceID      <= '0;
      fbatteryStat   <= '0;
      fValue         <= '0;
      fclusterID     <= '0;
      fdestinationID <= '0;
      drop_count     <= 8'd0;
      pkt_count      <= 8'd0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      idle_cnt <= idle_cnt_nx;
      ready_q  <= (state_nx == IDLE) || (state_nx == COLLECT);
      if (store) begin
        for (int i = 0; i < 5; i++) begin
          if (wr_idx == 3'(i)) cap[i] <= rx.in_data;
        end
        if (wr_idx == 3'd5) cap_csum <= rx.in_data;
      end
      if (load) begin
        fsourceID      <= cap[0];
        fbatteryStat   <= cap[1];
        fValue         <= cap[2];
        fclusterID     <= cap[3];
        fdestinationID <= cap[4];
      end
      if (drop_inc && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (pkt_inc) pkt_count <= pkt_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pkt_frame_rx.sv
// tb_pkt_frame_rx: directed and randomized frames against a frame-level
// reference model; expected en/err_csum events go into queues that a
// separate monitor pops when the DUT presents them.
module tb_pkt_frame_rx;
  localparam int W     = 16;
  localparam int MY_ID = 3;
  localparam int TO    = 255;

  typedef logic [4:0][W-1:0] frame_t;
  typedef struct { frame_t f; int cyc; } exp_t;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic         done_reward = 1'b0;
  logic [W-1:0] fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID;
  logic         en, busy, err_csum;
  logic [7:0]   drop_count, pkt_count;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         exp_drop = 0;
  int         resp_mode = 0;
  logic [7:0] exp_pkt = 8'd0;
  exp_t       en_q[$];
  int         err_q[$];

  pkt_frame_rx_if #(.WORD_WIDTH(W)) bus ();

  pkt_frame_rx #(.WORD_WIDTH(W), .MY_ID(MY_ID), .TIMEOUT(TO)) dut (
    .clock(clock), .rst(rst), .rx(bus),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
    .fclusterID(fclusterID), .fdestinationID(fdestinationID),
    .en(en), .done_reward(done_reward), .busy(busy),
    .drop_count(drop_count), .pkt_count(pkt_count), .err_csum(err_csum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] csum_of(frame_t f);
    int s = 0;
    for (int i = 0; i < 5; i++) s += int'(f[i]);
    return W'(s % 65536);
  endfunction

  function automatic logic [7:0] sat(int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send_word(logic [W-1:0] d, logic s);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = s;
    while (!bus.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("ready_timeout", bus.in_ready, 1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // Sends a frame with random inter-word gaps (and an optional long stall
  // after word stall_at), then records what the frame must produce.
  task automatic send_frame(frame_t f, logic [W-1:0] cs, int max_gap,
                            int stall_at, int stall_len);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      send_word((i == 5) ? cs : f[i], i == 0);
      if (i == stall_at) begin
        repeat (stall_len) @(negedge clock);
        if (stall_len >= TO) begin
          exp_drop++;
          return;
        end
      end else if (i < 5) begin
        repeat ($urandom_range(0, max_gap)) @(negedge clock);
      end
    end
    check("ready_low_in_check", bus.in_ready, 0);
    if (cs != csum_of(f)) begin
      exp_drop++;
      err_q.push_back(cyc);
    end else if (f[4] == W'(MY_ID) || f[4] == '1) begin
      e.f   = f;
      e.cyc = cyc + 1;
      en_q.push_back(e);
    end else begin
      exp_drop++;
    end
  endtask

  task automatic checkpoint();
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("busy_stuck", busy, 0);
    #2;
    check("drop_count", drop_count, sat(exp_drop));
    check("pkt_count", pkt_count, exp_pkt);
    check("ready_idle", bus.in_ready, 1);
    @(negedge clock);
  endtask

  // monitor: compares every en / err_csum the DUT presents
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (!rst) begin
        if (en) begin
          if (en_q.size() == 0) check("en_unexpected", en, 0);
          else begin
            e = en_q.pop_front();
            check("en_cycle", cyc, e.cyc);
            check("fsourceID", fsourceID, e.f[0]);
            check("fbatteryStat", fbatteryStat, e.f[1]);
            check("fValue", fValue, e.f[2]);
            check("fclusterID", fclusterID, e.f[3]);
            check("fdestinationID", fdestinationID, e.f[4]);
            check("pkt_count_at_en", pkt_count, exp_pkt);
          end
        end
        if (err_csum) begin
          if (err_q.size() == 0) check("err_unexpected", err_csum, 0);
          else check("err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  // reward-stage responder
  initial begin
    forever begin
      @(negedge clock);
      if (en && !rst) begin
        check("ready_low_issue", bus.in_ready, 0);
        if (resp_mode == 0) begin
          repeat (3) begin
            @(negedge clock);
            check("ready_low_wait", bus.in_ready, 0);
          end
          done_reward = 1'b1;
          @(negedge clock);
          done_reward = 1'b0;
          exp_pkt++;
          check("busy_after_done", busy, 0);
          check("ready_after_done", bus.in_ready, 1);
          check("pkt_after_done", pkt_count, exp_pkt);
        end else if (resp_mode == 1) begin
          done_reward = 1'b1;          // lands on the ISSUE cycle
          @(negedge clock);
          done_reward = 1'b0;
          check("done_in_issue_ignored", busy, 1);
          repeat (2) @(negedge clock);
          check("still_waiting", busy, 1);
          check("pkt_unchanged", pkt_count, exp_pkt);
          done_reward = 1'b1;
          @(negedge clock);
          done_reward = 1'b0;
          exp_pkt++;
          check("busy_after_late_done", busy, 0);
          check("pkt_after_late_done", pkt_count, exp_pkt);
        end
      end
    end
  end

  initial begin
    frame_t f;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_en", en, 0);
    check("rst_err", err_csum, 0);
    check("rst_drop", drop_count, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_fsrc", fsourceID, 0);
    check("rst_fdst", fdestinationID, 0);
    @(negedge clock);
    rst = 1'b0;
    #1;
    check("ready_before_first_edge", bus.in_ready, 0);
    @(negedge clock);
    check("ready_first_cycle", bus.in_ready, 1);

    // reference frame for this node
    f[0] = 16'd15; f[1] = 16'h5999; f[2] = 16'h0680; f[3] = 16'd1; f[4] = 16'd3;
    send_frame(f, 16'h602C, 0, -1, 0);
    checkpoint();
    send_frame(f, 16'h602D, 0, -1, 0);          // bad checksum
    checkpoint();
    f[4] = 16'd4;
    send_frame(f, csum_of(f), 0, -1, 0);        // foreign destination
    checkpoint();
    f[4] = 16'hFFFF;
    send_frame(f, csum_of(f), 0, -1, 0);        // broadcast
    checkpoint();

    // resync: new sof on the fourth word
    f[4] = 16'd3;
    send_word(16'h1111, 1'b1);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    exp_drop++;
    send_frame(f, csum_of(f), 0, -1, 0);
    checkpoint();

    // timeout: stall after word index 2
    send_word(f[0], 1'b1);
    send_word(f[1], 1'b0);
    send_word(f[2], 1'b0);
    repeat (TO - 1) @(negedge clock);
    check("busy_before_timeout", busy, 1);
    @(negedge clock);
    check("busy_after_timeout", busy, 0);
    exp_drop++;
    checkpoint();

    // longest legal gap
    send_frame(f, csum_of(f), 0, 2, TO - 1);
    checkpoint();

    // done_reward during ISSUE is ignored
    resp_mode = 1;
    send_frame(f, csum_of(f), 1, -1, 0);
    checkpoint();
    resp_mode = 0;

    // reset while in WAIT_DONE
    resp_mode = 2;
    f[0] = 16'hABCD;
    send_frame(f, csum_of(f), 0, -1, 0);
    n = 0;
    while (!en && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("en_before_reset", en, 1);
    @(negedge clock);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_fsrc", fsourceID, 0);
    check("mid_rst_fbat", fbatteryStat, 0);
    check("mid_rst_fval", fValue, 0);
    check("mid_rst_fdst", fdestinationID, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_pkt", pkt_count, 0);
    exp_drop = 0;
    exp_pkt  = 8'd0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    resp_mode = 0;
    f[2] = 16'h0F0F;
    send_frame(f, csum_of(f), 0, -1, 0);
    checkpoint();

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      frame_t rf;
      logic [W-1:0] cs;
      int kind, dsel, stall_at, stall_len, m;
      for (int k = 0; k < 5; k++) rf[k] = W'($urandom);
      dsel = $urandom_range(0, 2);
      rf[4] = (dsel == 0) ? W'(MY_ID) : (dsel == 1) ? '1 : W'($urandom_range(4, 65534));
      cs   = csum_of(rf);
      kind = $urandom_range(0, 9);
      if (kind <= 1) cs = cs ^ W'(1 << $urandom_range(0, 15));
      stall_at  = -1;
      stall_len = 0;
      if (kind == 4) begin stall_at = $urandom_range(0, 4); stall_len = TO - 1; end
      if (kind == 5) begin stall_at = $urandom_range(0, 4); stall_len = TO; end
      if (kind == 2) repeat ($urandom_range(1, 3)) send_word(W'($urandom), 1'b0);
      if (kind == 3) begin
        m = $urandom_range(1, 5);
        send_word(W'($urandom), 1'b1);
        for (int j = 1; j < m; j++) send_word(W'($urandom), 1'b0);
        exp_drop++;
      end
      resp_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send_frame(rf, cs, $urandom_range(0, 2), stall_at, stall_len);
      checkpoint();
    end
    resp_mode = 0;

    // drop counter saturation
    f[0] = 16'h0042;
    for (int s = 0; s < 260; s++) begin
      send_frame(f, csum_of(f) + 16'd1, 0, -1, 0);
      if (s % 20 == 19) checkpoint();
    end
    checkpoint();
    check("drop_saturated", drop_count, 255);

    check("en_queue_drained", en_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
